// File: rtl/branch_control.sv
// ---------------------------------------------------------------------------
// branch_control
//
// Branch-decision unit for the KGP-RISC core. Decodes the 6-bit opcode
// against the ALU flag register and tells the PC-select logic whether the
// program counter must be redirected. It also supplies the branch-class side
// signals needed by the register file (link write) and by the target mux
// (register vs. PC-relative target).
//
// Ports:
//   clk            in   1  system clock, rising-edge active
//   rst            in   1  asynchronous, active-high reset
//   opcode         in   6  instruction opcode field
//   fZero          in   1  zero flag
//   fSign          in   1  sign flag
//   fCarry         in   1  carry flag from the last ALU operation
//   out            out  1  branch taken (registered)
//   is_branch      out  1  opcode is one of the eight branch opcodes (registered)
//   link_en        out  1  write return address to link register, bl only
//   use_reg_target out  1  target comes from a register, br only
//
// Every output is registered: inputs present before rising edge N appear on
// the outputs after edge N. A fresh decision is captured on every cycle.
// ---------------------------------------------------------------------------
module branch_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       fZero,
   input  logic       fSign,
   input  logic       fCarry,
   output logic       out,
   output logic       is_branch,
   output logic       link_en,
   output logic       use_reg_target
);

   // Fixed branch opcode encodings.
   typedef enum logic [5:0] {
      OP_BR   = 6'b100000,
      OP_B    = 6'b101000,
      OP_BCY  = 6'b101001,
      OP_BNCY = 6'b101010,
      OP_BL   = 6'b101011,
      OP_BLTZ = 6'b110000,
      OP_BZ   = 6'b110001,
      OP_BNZ  = 6'b110010
   } branchOp_t;

   logic takenNext;
   logic branchNext;
   logic linkNext;
   logic regTargetNext;

   // Each opcode selects at most one flag. Picking the flag inside its own
   // case arm (rather than AND-ing every flag with an opcode match) keeps an
   // unused, possibly unknown flag from ever reaching the outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case, so paths that do
      // not mention a signal still assign it and no latch is inferred.
      takenNext     = 1'b0;
      branchNext    = 1'b0;
      linkNext      = 1'b0;
      regTargetNext = 1'b0;

      case (opcode)
         OP_B: begin
            takenNext  = 1'b1;
            branchNext = 1'b1;
         end
         OP_BR: begin
            takenNext     = 1'b1;
            branchNext    = 1'b1;
            regTargetNext = 1'b1;
         end
         OP_BL: begin
            takenNext  = 1'b1;
            branchNext = 1'b1;
            linkNext   = 1'b1;
         end
         OP_BCY: begin
            takenNext  = fCarry;
            branchNext = 1'b1;
         end
         OP_BNCY: begin
            takenNext  = ~fCarry;
            branchNext = 1'b1;
         end
         OP_BLTZ: begin
            takenNext  = fSign;
            branchNext = 1'b1;
         end
         OP_BZ: begin
            takenNext  = fZero;
            branchNext = 1'b1;
         end
         OP_BNZ: begin
            takenNext  = ~fZero;
            branchNext = 1'b1;
         end
         default: begin
            // Non-branch opcode: all defaults (0) hold.
         end
      endcase
   end

   // Output register. Reset clears the outputs immediately and discards any
   // decision that was about to be captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: only these four control flops exist; all are reset so the
         // PC-select logic never sees a stale redirect coming out of reset.
         out            <= 1'b0;
         is_branch      <= 1'b0;
         link_en        <= 1'b0;
         use_reg_target <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before the edge, independent of statement order.
         out            <= takenNext;
         is_branch      <= branchNext;
         link_en        <= linkNext;
         use_reg_target <= regTargetNext;
      end
   end

endmodule

// File: tb/tb_branch_control.sv
// ---------------------------------------------------------------------------
// tb_branch_control
//
// Self-checking bench for branch_control. The driver applies one input set
// per cycle on the falling edge and queues the expected registered response;
// a monitor pops one entry after each rising edge and compares it with
// {out, is_branch, link_en, use_reg_target}.
// ---------------------------------------------------------------------------
module tb_branch_control;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       fZero;
   logic       fSign;
   logic       fCarry;
   logic       out;
   logic       is_branch;
   logic       link_en;
   logic       use_reg_target;

   branch_control dut (
      .clk            (clk),
      .rst            (rst),
      .opcode         (opcode),
      .fZero          (fZero),
      .fSign          (fSign),
      .fCarry         (fCarry),
      .out            (out),
      .is_branch      (is_branch),
      .link_en        (link_en),
      .use_reg_target (use_reg_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected response packed as {out, is_branch, link_en, use_reg_target}.
   typedef struct {
      logic [3:0] exp;
      string      name;
   } expEntry_t;

   expEntry_t expQ[$];

   int vectors     = 0;
   int miscompares = 0;

   // Reference table for the sweep: flagSel 0 = none, 1 = zero, 2 = sign,
   // 3 = carry; inv inverts the selected flag.
   typedef struct {
      logic [5:0] op;
      logic       uncond;
      int         flagSel;
      logic       inv;
      logic       link;
      logic       regT;
   } refEntry_t;

   refEntry_t refTbl[8];

   task automatic initTable();
      refTbl[0] = '{6'b101000, 1'b1, 0, 1'b0, 1'b0, 1'b0}; // b
      refTbl[1] = '{6'b100000, 1'b1, 0, 1'b0, 1'b0, 1'b1}; // br
      refTbl[2] = '{6'b101011, 1'b1, 0, 1'b0, 1'b1, 1'b0}; // bl
      refTbl[3] = '{6'b101001, 1'b0, 3, 1'b0, 1'b0, 1'b0}; // bcy
      refTbl[4] = '{6'b101010, 1'b0, 3, 1'b1, 1'b0, 1'b0}; // bncy
      refTbl[5] = '{6'b110000, 1'b0, 2, 1'b0, 1'b0, 1'b0}; // bltz
      refTbl[6] = '{6'b110001, 1'b0, 1, 1'b0, 1'b0, 1'b0}; // bz
      refTbl[7] = '{6'b110010, 1'b0, 1, 1'b1, 1'b0, 1'b0}; // bnz
   endtask

   function automatic int flagSelOf(input logic [5:0] op);
      int sel;
      sel = 0;
      for (int i = 0; i < 8; i++)
         if (refTbl[i].op == op) sel = refTbl[i].flagSel;
      return sel;
   endfunction

   function automatic logic [3:0] model(input logic [5:0] op, input logic z,
                                        input logic s, input logic c);
      logic [3:0] r;
      logic       flag;
      r = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         if (refTbl[i].op == op) begin
            flag = (refTbl[i].flagSel == 1) ? z :
                   (refTbl[i].flagSel == 2) ? s :
                   (refTbl[i].flagSel == 3) ? c : 1'b0;
            r[3] = refTbl[i].uncond ? 1'b1 : (flag ^ refTbl[i].inv);
            r[2] = 1'b1;
            r[1] = refTbl[i].link;
            r[0] = refTbl[i].regT;
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] outs();
      return {out, is_branch, link_en, use_reg_target};
   endfunction

   task automatic check(input string name, input logic [3:0] act,
                        input logic [3:0] exp);
      vectors++;
      if ((act !== exp) || $isunknown(act)) begin
         miscompares++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   // Apply one input set now and queue its expected response.
   task automatic apply(input logic [5:0] op, input logic z, input logic s,
                        input logic c, input logic [3:0] exp, input string name);
      expEntry_t e;
      opcode = op;
      fZero  = z;
      fSign  = s;
      fCarry = c;
      e.exp  = exp;
      e.name = name;
      expQ.push_back(e);
   endtask

   // Apply on the current falling edge, then hold for one full cycle.
   task automatic drive(input logic [5:0] op, input logic z, input logic s,
                        input logic c, input logic [3:0] exp, input string name);
      apply(op, z, s, c, exp, name);
      @(negedge clk);
   endtask

   // Monitor: one registered decision per rising edge.
   initial begin
      expEntry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && expQ.size() > 0) begin
            e = expQ.pop_front();
            check(e.name, outs(), e.exp);
         end
      end
   end

   logic [5:0] nonBranch[3];

   initial begin
      initTable();
      nonBranch[0] = 6'b000000;
      nonBranch[1] = 6'b100001;
      nonBranch[2] = 6'b111111;

      rst    = 1'b1;
      opcode = 6'b000000;
      fZero  = 1'b0;
      fSign  = 1'b0;
      fCarry = 1'b0;
      #2;
      check("reset_init", outs(), 4'b0000);

      // Release reset with b held: first decision on the next edge.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive(6'b101000, 1'b0, 1'b0, 1'b0, 4'b1100, "post_reset_b");

      // Outputs now show a taken b; assert reset mid-cycle.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_reset", outs(), 4'b0000);
      @(posedge clk);
      #1;
      check("reset_hold", outs(), 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      // Zero-flag branches.
      drive(6'b110001, 1'b0, 1'b1, 1'b1, 4'b0100, "bz_z0");
      drive(6'b110001, 1'b1, 1'b0, 1'b0, 4'b1100, "bz_z1");
      drive(6'b110010, 1'b0, 1'b1, 1'b1, 4'b1100, "bnz_z0");
      drive(6'b110010, 1'b1, 1'b0, 1'b0, 4'b0100, "bnz_z1");

      // Carry and sign branches; other flags set to opposing values.
      drive(6'b101001, 1'b1, 1'b0, 1'b1, 4'b1100, "bcy_c1");
      drive(6'b101001, 1'b1, 1'b1, 1'b0, 4'b0100, "bcy_c0");
      drive(6'b101010, 1'b0, 1'b0, 1'b0, 4'b1100, "bncy_c0");
      drive(6'b101010, 1'b1, 1'b1, 1'b1, 4'b0100, "bncy_c1");
      drive(6'b110000, 1'b0, 1'b1, 1'b0, 4'b1100, "bltz_s1");
      drive(6'b110000, 1'b1, 1'b0, 1'b1, 4'b0100, "bltz_s0");

      // Unconditional branches with random flags.
      for (int i = 0; i < 4; i++) begin
         drive(6'b101000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'b1100, "b_uncond");
         drive(6'b101011, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'b1110, "bl_uncond");
         drive(6'b100000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'b1101, "br_uncond");
      end

      // Non-branch opcodes under every flag combination.
      for (int n = 0; n < 3; n++) begin
         for (int f = 0; f < 8; f++) begin
            logic [2:0] fb;
            fb = 3'(f);
            drive(nonBranch[n], fb[2], fb[1], fb[0], 4'b0000,
                  $sformatf("nonbranch op=%b f=%b", nonBranch[n], fb));
         end
      end

      // Exhaustive sweep; second pass drives X on flags the opcode ignores.
      for (int pass = 0; pass < 2; pass++) begin
         for (int op = 0; op < 64; op++) begin
            for (int f = 0; f < 8; f++) begin
               logic [5:0] o;
               logic [2:0] fb;
               logic       zd, sd, cd;
               int         sel;
               o   = 6'(op);
               fb  = 3'(f);
               sel = flagSelOf(o);
               zd  = fb[2];
               sd  = fb[1];
               cd  = fb[0];
               if (pass == 1) begin
                  if (sel != 1) zd = 1'bx;
                  if (sel != 2) sd = 1'bx;
                  if (sel != 3) cd = 1'bx;
               end
               drive(o, zd, sd, cd, model(o, fb[2], fb[1], fb[0]),
                     $sformatf("sweep%0d op=%b f=%b", pass, o, fb));
            end
         end
      end

      // Let the monitor drain the queue, bounded.
      for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
      if (expQ.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d responses still pending, want 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_control.md
Name: branch_control

Overview:
- Branch-decision unit of the KGP-RISC processor; sits between the instruction decoder/ALU flag register and PC-select logic.
- Decodes the 6-bit opcode against the zero/sign/carry flags and raises `out` when the PC must be redirected.
- Also provides branch-class side signals: link write for `bl`, register-target select for `br`.
- All outputs are registered on one clock.

Parameters:
- None. Opcode encodings are fixed constants listed under Behaviour.

Ports:
- clk  input  1  system clock; rising-edge active
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  instruction opcode field
- fZero  input  1  zero flag (1 = operand/result equals 0)
- fSign  input  1  sign flag (1 = operand negative)
- fCarry  input  1  carry flag from the last ALU operation
- out  output  1  branch taken
- is_branch  output  1  opcode belongs to the branch class, whether taken or not
- link_en  output  1  write return address to the link register (`bl` only)
- use_reg_target  output  1  target comes from a register (`br`), not the PC-relative immediate

Behaviour:
- Opcode map and taken condition (`out` next value):
  - 101000 `b`: 1, unconditional
  - 100000 `br`: 1, unconditional; use_reg_target=1
  - 101011 `bl`: 1, unconditional; link_en=1
  - 101001 `bcy`: fCarry
  - 101010 `bncy`: ~fCarry
  - 110000 `bltz`: fSign
  - 110001 `bz`: fZero
  - 110010 `bnz`: ~fZero
  - any other opcode (e.g. 000000, ALU ops): out=0, is_branch=0, link_en=0, use_reg_target=0
- is_branch is 1 for exactly the eight opcodes above, regardless of flag values.
- Flags not used by the current opcode are don't-care and must not affect any output.
- Decode is purely combinational from opcode and flags. All four outputs are captured in flip-flops on the rising edge of clk.
- Latency: inputs valid before edge N appear on outputs after edge N. No handshake; a new decision is made every cycle.
- Reset: when rst=1, all four outputs go to 0 immediately, asynchronously, and stay 0 while rst is held. The first decision is captured on the first rising edge after rst deasserts.
- Reset mid-operation: any pending decision is discarded; outputs read 0.
- Simultaneous flags: e.g. fZero=1 with fCarry=1 under `bcy` gives taken=1. Only the selected flag matters.
- Unknown/X on an unused flag must not propagate to outputs. Use case/mux selection, not AND-OR of all flags.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with opcode=101000 → all outputs 0 at once. Release rst, hold opcode=101000 → after next edge out=1, is_branch=1.
- Zero branches, one input set per cycle:
  - bz (110001), fZero=0 → out=0
  - bz, fZero=1 → out=1
  - bnz (110010), fZero=0 → out=1
  - bnz, fZero=1 → out=0
  - Each result appears one cycle after the inputs.
- Carry/sign branches:
  - bcy (101001), fCarry=1 → out=1
  - bcy, fCarry=0 → out=0
  - bncy (101010), fCarry=0 → out=1
  - bncy, fCarry=1 → out=0
  - bltz (110000), fSign=1 → out=1
  - bltz, fSign=0 → out=0
- Unconditional branches with all flags randomized each cycle:
  - b (101000) → out=1, link_en=0, use_reg_target=0
  - bl (101011) → out=1, link_en=1
  - br (100000) → out=1, use_reg_target=1
- Non-branch opcodes: 000000, 100001, 111111, each with all eight flag combinations → out=is_branch=link_en=use_reg_target=0.
- Exhaustive sweep: all 64 opcodes × 8 flag combinations, compared against a reference model with one-cycle delay. Include X driven on unused flags → no X on outputs.
